mem_access_unit: RTL and testbench

//  Memory stage between execute and writeback; produces ReadDataW/ALUOutW/MemtoRegW consumed by the writeback result mux.

---
 rtl/mem_access_unit_pkg.sv | 31 +++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_data_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_unit_pkg;

    // RV32I load/store size encodings (loads and stores share codes 000/001/010)
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {StIdle, StReq, StWait} lsu_state_t;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} access_size_t;

    // Unknown encodings fall back to a full-word access.
    function automatic access_size_t access_size(input logic [2:0] funct3, input logic is_store);
        access_size_t sz;
        case (funct3)
            FUNCT3_LB:  sz = SzByte;
            FUNCT3_LH:  sz = SzHalf;
            FUNCT3_LBU: sz = is_store ? SzWord : SzByte;
            FUNCT3_LHU: sz = is_store ? SzWord : SzHalf;
            default:    sz = SzWord;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus between the LSU and memory.
interface mem_access_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit_data_align.sv
// Combinational lane steering: load extract/extend, store byte-enables/replication,
// and misalignment detection for a 32-bit, 4-lane data bus.
module mem_access_unit_data_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        is_store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);
    access_size_t size;
    logic [7:0]   byte_sel;
    logic [15:0]  half_sel;
    logic         zero_ext;

    // Decode size, then steer store lanes and extract/extend the load lane
    always_comb begin
        size        = access_size(funct3_i, is_store_i);
        byte_sel    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        zero_ext    = funct3_i[2];
        be_o        = 4'b1111;
        wdata_o     = wdata_i;
        load_data_o = rdata_i;
        misalign_o  = 1'b0;
        unique case (size)
            SzByte: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{wdata_i[7:0]}};
                load_data_o = {{24{byte_sel[7] & ~zero_ext}}, byte_sel};
            end
            SzHalf: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{wdata_i[15:0]}};
                load_data_o = {{16{half_sel[15] & ~zero_ext}}, half_sel};
                misalign_o  = addr_lo_i[0];
            end
            default: begin
                misalign_o  = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory pipeline stage: issues data-memory accesses, stalls upstream while one is
// outstanding, and registers the writeback-side results.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   ALUOutM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    input  logic              MemtoRegM,
    output logic              StallM,
    mem_access_unit_if.master dmem,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   ALUOutW,
    output logic              MemtoRegW,
    output logic              ValidW,
    output logic              MisalignW,
    output logic              TimeoutW
);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    lsu_state_t      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] read_data_q, read_data_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic            valid_q, valid_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    logic            memop, is_store, misalign, req, complete;
    logic            timeout_evt, misalign_evt, load_ok, cnt_hit;
    logic [3:0]      be;
    logic [31:0]     st_wdata, ld_data;

    // A store wins when both read and write are requested.
    assign is_store = MemWriteM;
    assign memop    = MemReadM | MemWriteM;
    assign cnt_hit  = (cnt_q == TimeoutCnt);

    mem_access_unit_data_align u_align (
        .funct3_i    (Funct3M),
        .is_store_i  (is_store),
        .addr_lo_i   (ALUOutM[1:0]),
        .wdata_i     (WriteDataM),
        .rdata_i     (dmem.rdata),
        .be_o        (be),
        .wdata_o     (st_wdata),
        .load_data_o (ld_data),
        .misalign_o  (misalign)
    );

    // Outputs are gated by reset so a held upstream op cannot issue while in reset
    assign dmem.req   = req & rst;
    assign dmem.we    = req & rst & is_store;
    assign dmem.addr  = {ALUOutM[XLEN-1:2], 2'b00};
    assign dmem.wdata = st_wdata;
    assign dmem.be    = be;
    assign StallM     = memop & ~complete & rst;

    // FSM next state, request/completion decode and writeback-register next values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req          = 1'b0;
        complete     = 1'b0;
        timeout_evt  = 1'b0;
        misalign_evt = 1'b0;
        load_ok      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!memop) begin
                    complete = 1'b1;
                end else if (misalign) begin
                    complete     = 1'b1;
                    misalign_evt = 1'b1;
                end else begin
                    req   = 1'b1;
                    cnt_d = 8'd0;
                    if (!dmem.gnt) begin
                        state_d = StReq;
                    end else if (is_store || dmem.rvalid) begin
                        complete = 1'b1;
                        load_ok  = ~is_store;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StReq: begin
                if (cnt_hit) begin
                    complete    = 1'b1;
                    timeout_evt = 1'b1;
                    state_d     = StIdle;
                end else begin
                    req   = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (dmem.gnt) begin
                        if (is_store || dmem.rvalid) begin
                            complete = 1'b1;
                            load_ok  = ~is_store;
                            state_d  = StIdle;
                        end else begin
                            state_d = StWait;
                        end
                    end
                end
            end
            StWait: begin
                if (cnt_hit) begin
                    complete    = 1'b1;
                    timeout_evt = 1'b1;
                    state_d     = StIdle;
                end else if (dmem.rvalid) begin
                    complete = 1'b1;
                    load_ok  = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A stalled cycle leaves a bubble (everything zero) in the W registers
        valid_d      = complete;
        alu_out_d    = complete ? ALUOutM : '0;
        mem_to_reg_d = complete & MemtoRegM;
        read_data_d  = load_ok ? XLEN'(ld_data) : '0;
        misalign_d   = misalign_evt;
        timeout_d    = timeout_evt;
    end

    // State, wait counter and writeback registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            read_data_q  <= '0;
            alu_out_q    <= '0;
            mem_to_reg_q <= 1'b0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            alu_out_q    <= alu_out_d;
            mem_to_reg_q <= mem_to_reg_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ReadDataW = read_data_q;
    assign ALUOutW   = alu_out_q;
    assign MemtoRegW = mem_to_reg_q;
    assign ValidW    = valid_q;
    assign MisalignW = misalign_q;
    assign TimeoutW  = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a scoreboard of expected W results.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALUOutM, WriteDataM;
    logic        MemReadM, MemWriteM, MemtoRegM;
    logic [2:0]  Funct3M;
    logic        StallM;
    logic [31:0] ReadDataW, ALUOutW;
    logic        MemtoRegW, ValidW, MisalignW, TimeoutW;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32)) dmem_if ();

    mem_access_unit #(.XLEN(32), .TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .MemtoRegM  (MemtoRegM),
        .StallM     (StallM),
        .dmem       (dmem_if),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .MemtoRegW  (MemtoRegW),
        .ValidW     (ValidW),
        .MisalignW  (MisalignW),
        .TimeoutW   (TimeoutW)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic        m2r;
        int          gdly;      // cycle of gnt
        int          rdly;      // rvalid cycles after gnt
        int          spur;      // cycle of a stray rvalid with junk data (-1 none)
        logic        exp_req;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        exp_to;
        int          exp_stall;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                       input logic m2r, input int gdly, input int rdly, input int spur,
                       input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input logic exp_to,
                       input int exp_stall);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdat = wdat;
        v.rdat = rdat; v.m2r = m2r; v.gdly = gdly; v.rdly = rdly; v.spur = spur;
        v.exp_req = exp_req; v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_rd = exp_rd;
        v.exp_mis = exp_mis; v.exp_to = exp_to; v.exp_stall = exp_stall;
        vecs.push_back(v);
    endtask

    // Drive one op, play the memory side, then pop the scoreboard at completion.
    task automatic run_op(input vec_t v);
        int   stalls = 0;
        bit   done   = 0;
        vec_t e;
        @(negedge clk);
        MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3; ALUOutM = v.addr;
        WriteDataM = v.wdat; MemtoRegM = v.m2r;
        sb_q.push_back(v);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            dmem_if.gnt    = (cyc == v.gdly);
            dmem_if.rvalid = (cyc == v.gdly + v.rdly) || (cyc == v.spur);
            dmem_if.rdata  = (cyc == v.spur) ? 32'hDEAD_BEEF : v.rdat;
            #1;
            if (cyc == 0) begin
                chk({v.name, ".req"}, {31'd0, dmem_if.req}, {31'd0, v.exp_req});
                if (v.exp_req) begin
                    chk({v.name, ".addr"}, dmem_if.addr, {v.addr[31:2], 2'b00});
                    chk({v.name, ".we"}, {31'd0, dmem_if.we}, {31'd0, v.wr});
                    if (v.wr) begin
                        chk({v.name, ".be"}, {28'd0, dmem_if.be}, {28'd0, v.exp_be});
                        chk({v.name, ".wdata"}, dmem_if.wdata, v.exp_wd);
                    end
                end
            end
            if (!StallM) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
            if (!done) chk({v.name, ".bubble"}, {31'd0, ValidW}, 32'd0);
        end
        dmem_if.gnt = 1'b0;
        dmem_if.rvalid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.complete: no completion within 400 cycles", v.name);
        end
        chk({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.scoreboard: result with empty queue", v.name);
        end else begin
            e = sb_q.pop_front();
            chk({e.name, ".ValidW"}, {31'd0, ValidW}, 32'd1);
            chk({e.name, ".ReadDataW"}, ReadDataW, e.exp_rd);
            chk({e.name, ".ALUOutW"}, ALUOutW, e.addr);
            chk({e.name, ".MemtoRegW"}, {31'd0, MemtoRegW}, {31'd0, e.m2r});
            chk({e.name, ".MisalignW"}, {31'd0, MisalignW}, {31'd0, e.exp_mis});
            chk({e.name, ".TimeoutW"}, {31'd0, TimeoutW}, {31'd0, e.exp_to});
        end
    endtask

    task automatic chk_w_zero(input string name);
        chk({name, ".req"}, {31'd0, dmem_if.req}, 32'd0);
        chk({name, ".StallM"}, {31'd0, StallM}, 32'd0);
        chk({name, ".ValidW"}, {31'd0, ValidW}, 32'd0);
        chk({name, ".ALUOutW"}, ALUOutW, 32'd0);
        chk({name, ".ReadDataW"}, ReadDataW, 32'd0);
        chk({name, ".MemtoRegW"}, {31'd0, MemtoRegW}, 32'd0);
        chk({name, ".MisalignW"}, {31'd0, MisalignW}, 32'd0);
        chk({name, ".TimeoutW"}, {31'd0, TimeoutW}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //  name             rd wr f3      addr          wdat          rdat          m2r g  r     spur
        //                   req be       wdata         rdata        mis to stall
        add("lb_neg",        1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 1, 0, 0,    -1,
            1, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 0, 0);
        add("lhu_wait",      1, 0, 3'b101, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 2, 3,    -1,
            1, 4'b0000, 32'h0,        32'h0000_8001, 0, 0, 5);
        add("sb_lane1",      0, 1, 3'b000, 32'h0000_0011, 32'h0000_00AB, 32'h0,       0, 1, 0,    -1,
            1, 4'b0010, 32'hABAB_ABAB, 32'h0,        0, 0, 1);
        add("sw_misalign",   0, 1, 3'b010, 32'h0000_0006, 32'h1234_5678, 32'h0,       0, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         1, 0, 0);
        add("add_pass",      0, 0, 3'b000, 32'h1234_5678, 32'h0,        32'hFFFF_FFFF, 0, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         0, 0, 0);
        add("lh_neg",        1, 0, 3'b001, 32'h0000_2000, 32'h0,        32'h1234_F00D, 1, 0, 1,    -1,
            1, 4'b0000, 32'h0,        32'hFFFF_F00D, 0, 0, 1);
        add("lbu_lane1",     1, 0, 3'b100, 32'h0000_3001, 32'h0,        32'h0000_9A00, 1, 0, 0,    -1,
            1, 4'b0000, 32'h0,        32'h0000_009A, 0, 0, 0);
        add("lw_stray_rv",   1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_BABE, 1, 2, 1,    1,
            1, 4'b0000, 32'h0,        32'hCAFE_BABE, 0, 0, 3);
        add("sh_hi",         0, 1, 3'b001, 32'h0000_0022, 32'h5555_BEEF, 32'h0,       0, 0, 0,    -1,
            1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 0);
        add("sh_lo",         0, 1, 3'b001, 32'h0000_0020, 32'h0000_1234, 32'h0,       0, 0, 0,    -1,
            1, 4'b0011, 32'h1234_1234, 32'h0,        0, 0, 0);
        add("lh_misalign",   1, 0, 3'b001, 32'h0000_2001, 32'h0,        32'h0,         1, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         1, 0, 0);
        add("lw_f3_011",     1, 0, 3'b011, 32'h0000_0050, 32'h0,        32'h1122_3344, 1, 0, 0,    -1,
            1, 4'b0000, 32'h0,        32'h1122_3344, 0, 0, 0);
        add("ld_f3_110_mis", 1, 0, 3'b110, 32'h0000_0052, 32'h0,        32'h0,         1, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         1, 0, 0);
        add("sb_lane3",      0, 1, 3'b000, 32'h0000_0013, 32'h0000_00C3, 32'h0,       0, 0, 0,    -1,
            1, 4'b1000, 32'hC3C3_C3C3, 32'h0,        0, 0, 0);
        add("rdwr_store",    1, 1, 3'b010, 32'h0000_0040, 32'h0102_0304, 32'hFFFF_FFFF, 0, 0, 0,  -1,
            1, 4'b1111, 32'h0102_0304, 32'h0,        0, 0, 0);
        add("lw_timeout",    1, 0, 3'b010, 32'h0000_0080, 32'h0,        32'h5555_5555, 1, 0, 1000, -1,
            1, 4'b0000, 32'h0,        32'h0,         0, 1, 256);
        add("add_late_rv",   0, 0, 3'b000, 32'h0000_0099, 32'h0,        32'h7777_7777, 0, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         0, 0, 0);
        add("sw_wait3",      0, 1, 3'b010, 32'h0000_0044, 32'hA5A5_A5A5, 32'h0,       0, 3, 0,    -1,
            1, 4'b1111, 32'hA5A5_A5A5, 32'h0,        0, 0, 3);
        add("add_pre_rst",   0, 0, 3'b000, 32'h0000_ABCD, 32'h0,        32'h0,         1, 0, 0,    -1,
            0, 4'b0000, 32'h0,        32'h0,         0, 0, 0);
        add("lw_post_rst",   1, 0, 3'b010, 32'h0000_0304, 32'h0,        32'h0BAD_F00D, 1, 1, 1,    -1,
            1, 4'b0000, 32'h0,        32'h0BAD_F00D, 0, 0, 2);

        // Reset with a load presented upstream: nothing may issue or stall
        rst = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUOutM = 32'h100;
        WriteDataM = '0; MemtoRegM = 1'b1;
        dmem_if.gnt = 1'b0; dmem_if.rvalid = 1'b0; dmem_if.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_w_zero("reset");
        @(negedge clk);
        MemReadM = 1'b0; MemtoRegM = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size() - 2; i++) run_op(vecs[i]);

        // Reset right after a completion with a fresh load already issuing
        run_op(vecs[vecs.size() - 2]);
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; ALUOutM = 32'h300;
        MemtoRegM = 1'b1;
        #1;
        chk("rst_idle.req_before", {31'd0, dmem_if.req}, 32'd1);
        rst = 1'b0;
        #1;
        chk_w_zero("rst_idle");
        @(negedge clk);
        rst = 1'b1;

        // Reset while waiting for rvalid; stale rvalid after release must be ignored
        dmem_if.gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wait.bubble", {31'd0, ValidW}, 32'd0);
        @(negedge clk);
        dmem_if.gnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wait.stall", {31'd0, StallM}, 32'd1);
        rst = 1'b0;
        #1;
        chk_w_zero("rst_wait");
        MemReadM = 1'b0; MemtoRegM = 1'b0; ALUOutM = 32'h5A5A;
        dmem_if.rvalid = 1'b1; dmem_if.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_add.ValidW", {31'd0, ValidW}, 32'd1);
        chk("rst_add.ALUOutW", ALUOutW, 32'h5A5A);
        chk("rst_add.ReadDataW", ReadDataW, 32'd0);
        @(negedge clk);
        dmem_if.rvalid = 1'b0;
        run_op(vecs[vecs.size() - 1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
